motor_drive_seq: RTL
====================

// Module: motor_drive_seq
// PURPOSE
//  Drive sequencer between the line-tracker decision logic and the two motor_pwm
//  channels. Debounces the requested drive mode and maps it to per-wheel duty targets.
//  Slews each wheel's 10-bit duty toward its target at a fixed rate, so starts, turns
//  and stops are ramped rather than stepped.
//  Outputs feed the motor_pwm duty inputs directly, one output per wheel.
// PARAMETERS
//  TICK_DIV    100_000  clk cycles per slew tick (1 kHz at 100 MHz); >=2
//  STEP        16       duty increment per tick while accelerating/turning
//  BRAKE_STEP  64       duty decrement per tick while in BRAKE
//  DEB_TICKS   4        ticks a new mode must stay stable before acceptance; >=1
//  DUTY_FULL   1000     straight-line duty (of 1024)
//  DUTY_TURN   400      inner-wheel duty in a turn
// PORTS
//  clk         in   1   system clock, 100 MHz
//  rst         in   1   synchronous reset, active-low
//  en          in   1   1 = drive allowed; 0 = forced STOP request
//  mode        in   4   requested mode: 0 STOP, 1 STRI, 2 RT, 3 LT, 4..15 = STOP
//  left_duty   out  10  duty to left motor_pwm
//  right_duty  out  10  duty to right motor_pwm
//  state       out  2   0 IDLE, 1 RAMP, 2 HOLD, 3 BRAKE
//  settled     out  1   1 when both duties equal their targets
// BEHAVIOUR
//  Reset (rst==0 at a clk edge): duties 0, targets 0, accepted mode STOP, state IDLE,
//   settled 1, tick and debounce counters 0. Reset mid-ramp takes effect on that edge.
//  Tick: a free counter counts 0..TICK_DIV-1. tick=1 for the single cycle when the
//   counter equals TICK_DIV-1, then it wraps to 0.
//  Effective request: req = (en==0 || mode>3) ? STOP : mode[1:0].
//  Debounce:
//   - req != candidate: candidate<=req, deb_cnt<=0 (this takes priority over a
//     same-cycle tick).
//   - Otherwise, on each tick: deb_cnt++. When deb_cnt reaches DEB_TICKS, the
//     accepted mode <= candidate.
//   - Exception: a STOP req caused by en==0 is accepted on the next edge with no
//     debounce.
//  Targets (L,R): STOP (0,0); STRI (FULL,FULL); RT (FULL,TURN); LT (TURN,FULL).
//   Targets update the cycle after acceptance.
//  Slew (per wheel, on tick only):
//   - d<t: d<=min(d+STEP,t).
//   - d>t: d<=max(d-s,t), where s=BRAKE_STEP in BRAKE, else STEP.
//   - Use an 11-bit intermediate; never wrap below 0 or above 1023.
//   - A mode change mid-ramp retargets from the current duty; there is no restart
//     from 0.
//  FSM (registered, evaluated every cycle):
//   - IDLE:  both d and t are 0. -> RAMP when a target becomes nonzero.
//   - RAMP:  any d!=t, accepted mode != STOP. -> HOLD when all d==t;
//            -> BRAKE on acceptance of STOP.
//   - HOLD:  all d==t, t nonzero. -> RAMP on target change; -> BRAKE on STOP.
//   - BRAKE: accepted STOP, ramping down. -> IDLE when both d==0;
//            -> RAMP if a non-STOP mode is accepted before reaching 0.
//  settled = (left_duty==tL && right_duty==tR), combinational from registers.
//  Latency: mode change to first duty change = DEB_TICKS ticks, plus up to 1 tick,
//   plus 2 cycles.
// STRUCTURE
//  motor_pkg:
//   - mode codes STOP/STRI/RT/LT
//   - FSM state encodings
//   - DUTY_FULL/DUTY_TURN defaults
//   - 10-bit duty width constant
//  Sub-module motor_slew: one instance per wheel.
//   - Inputs: clk, rst, tick, brake, target[9:0], step sizes.
//   - Outputs: duty[9:0], at_target.
//  Top holds the tick prescaler, the debounce logic, the target mapping and the FSM.
// TESTING (TICK_DIV=4, DEB_TICKS=2, STEP=16, BRAKE_STEP=64 for speed)
//  1 Reset: hold rst=0 for 3 cycles with mode=1.
//    -> duties 0, state IDLE, settled 1.
//  2 Start: mode=1 held after reset.
//    -> STRI accepted after 2 ticks; duties go 16, 32, ... per tick.
//    -> Exactly 1000 (no overshoot) on the 63rd tick; HOLD, settled 1.
//  3 Turn: from HOLD at 1000/1000, set mode=2.
//    -> left stays 1000; right steps 984, 968, ... to 400, then clamps at 400.
//    -> State RAMP, then HOLD.
//  4 Glitch: in HOLD, mode=3 for 1 tick, then back to 1.
//    -> No accept; duties unchanged; state stays HOLD.
//  5 Brake: en=0 at 1000/1000.
//    -> BRAKE next cycle; duties step down 64 per tick: 936, ..., 40, then 0.
//    -> State IDLE on reaching 0; mode=9 behaves identically (after debounce).
//  6 Reset mid-ramp: rst=0 while left=480 in RAMP.
//    -> Next edge: duties 0, IDLE.
//    -> No tick is carried across reset (tick counter restarts at 0).

Source files
------------

// File: rtl/motor_pkg.sv
// Shared mode codes, FSM encodings and duty constants for the motor drive sequencer.
package motor_pkg;

  localparam int DUTY_W        = 10;
  localparam int DUTY_FULL_DEF = 1000;
  localparam int DUTY_TURN_DEF = 400;

  typedef enum logic [1:0] {
    M_STOP = 2'd0,
    M_STRI = 2'd1,
    M_RT   = 2'd2,
    M_LT   = 2'd3
  } mode_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RAMP  = 2'd1,
    S_HOLD  = 2'd2,
    S_BRAKE = 2'd3
  } state_t;

  // Returns {left, right} duty targets for an accepted mode.
  function automatic logic [2*DUTY_W-1:0] mode_targets(
    input mode_t             m,
    input logic [DUTY_W-1:0] full,
    input logic [DUTY_W-1:0] turn
  );
    case (m)
      M_STRI:  mode_targets = {full, full};
      M_RT:    mode_targets = {full, turn};
      M_LT:    mode_targets = {turn, full};
      default: mode_targets = '0;
    endcase
  endfunction

endpackage

// File: rtl/motor_slew.sv
// Per-wheel duty slew limiter: moves duty one step toward target on each tick,
// clamping at the target so it never overshoots or wraps.
module motor_slew
  import motor_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              tick,
  input  logic              brake,
  input  logic [DUTY_W-1:0] target,
  input  logic [DUTY_W-1:0] step,
  input  logic [DUTY_W-1:0] brake_step,
  output logic [DUTY_W-1:0] duty,
  output logic              at_target
);

  logic [DUTY_W-1:0] dec;
  logic [DUTY_W:0]   up;
  logic [DUTY_W-1:0] nxt;

  always_comb begin
    dec = brake ? brake_step : step;
    up  = {1'b0, duty} + {1'b0, step};
    nxt = duty;
    if (duty < target) begin
      nxt = (up > {1'b0, target}) ? target : up[DUTY_W-1:0];
    end else if (duty > target) begin
      // Compare before subtracting so a large brake step cannot underflow.
      nxt = ({1'b0, duty} < ({1'b0, target} + {1'b0, dec})) ? target : duty - dec;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      duty <= '0;
    end else if (tick) begin
      duty <= nxt;
    end
  end

  assign at_target = (duty == target);

endmodule

// File: rtl/motor_drive_seq.sv
// Drive sequencer: debounces the requested mode, maps it to per-wheel duty targets
// and ramps both wheel duties toward them at a fixed per-tick rate.
module motor_drive_seq
  import motor_pkg::*;
#(
  parameter int TICK_DIV   = 100_000,
  parameter int STEP       = 16,
  parameter int BRAKE_STEP = 64,
  parameter int DEB_TICKS  = 4,
  parameter int DUTY_FULL  = DUTY_FULL_DEF,
  parameter int DUTY_TURN  = DUTY_TURN_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [3:0]        mode,
  output logic [DUTY_W-1:0] left_duty,
  output logic [DUTY_W-1:0] right_duty,
  output logic [1:0]        state,
  output logic              settled
);

  localparam int TW = $clog2(TICK_DIV);
  localparam int DW = $clog2(DEB_TICKS + 1);

  logic [TW-1:0]       tick_cnt;
  logic                tick;
  mode_t               req;
  mode_t               cand;
  mode_t               acc;
  logic [DW-1:0]       deb_cnt;
  logic [DUTY_W-1:0]   tgt_l;
  logic [DUTY_W-1:0]   tgt_r;
  logic [2*DUTY_W-1:0] want;
  logic                at_l;
  logic                at_r;
  state_t              st;
  state_t              nxt_st;

  assign tick = (tick_cnt == TW'(TICK_DIV - 1));

  always_ff @(posedge clk) begin
    if (!rst || tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  assign req = (!en || mode > 4'd3) ? M_STOP : mode_t'(mode[1:0]);

  // Drive-disable bypasses the debounce so the wheels start braking immediately.
  always_ff @(posedge clk) begin
    if (!rst || !en) begin
      cand    <= M_STOP;
      acc     <= M_STOP;
      deb_cnt <= '0;
    end else if (req != cand) begin
      cand    <= req;
      deb_cnt <= '0;
    end else if (tick && deb_cnt != DW'(DEB_TICKS)) begin
      deb_cnt <= deb_cnt + 1'b1;
      if (deb_cnt == DW'(DEB_TICKS - 1)) begin
        acc <= cand;
      end
    end
  end

  assign want = mode_targets(acc, DUTY_W'(DUTY_FULL), DUTY_W'(DUTY_TURN));

  always_ff @(posedge clk) begin
    if (!rst) begin
      tgt_l <= '0;
      tgt_r <= '0;
    end else begin
      {tgt_l, tgt_r} <= want;
    end
  end

  motor_slew u_slew_l (
    .clk        (clk),
    .rst        (rst),
    .tick       (tick),
    .brake      (st == S_BRAKE),
    .target     (tgt_l),
    .step       (DUTY_W'(STEP)),
    .brake_step (DUTY_W'(BRAKE_STEP)),
    .duty       (left_duty),
    .at_target  (at_l)
  );

  motor_slew u_slew_r (
    .clk        (clk),
    .rst        (rst),
    .tick       (tick),
    .brake      (st == S_BRAKE),
    .target     (tgt_r),
    .step       (DUTY_W'(STEP)),
    .brake_step (DUTY_W'(BRAKE_STEP)),
    .duty       (right_duty),
    .at_target  (at_r)
  );

  assign settled = at_l && at_r;

  always_ff @(posedge clk) begin
    if (!rst) begin
      st <= S_IDLE;
    end else begin
      st <= nxt_st;
    end
  end

  // HOLD is only entered once the targets reflect the accepted mode as well.
  always_comb begin
    nxt_st = st;
    case (st)
      S_IDLE:  if (tgt_l != '0 || tgt_r != '0) nxt_st = S_RAMP;
      S_RAMP:  if (acc == M_STOP) nxt_st = S_BRAKE;
               else if (settled && {tgt_l, tgt_r} == want) nxt_st = S_HOLD;
      S_HOLD:  if (acc == M_STOP) nxt_st = S_BRAKE;
               else if (!settled || {tgt_l, tgt_r} != want) nxt_st = S_RAMP;
      S_BRAKE: if (acc != M_STOP) nxt_st = S_RAMP;
               else if (left_duty == '0 && right_duty == '0) nxt_st = S_IDLE;
      default: nxt_st = S_IDLE;
    endcase
  end

  assign state = st;

endmodule
